// File: rtl/e_ppn_add_sub_seq_if.sv
// Start/done operand and result bundle for the digit-serial add/sub/compare unit.
interface e_ppn_add_sub_seq_if #(
  parameter int unsigned WIDTH = 257
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
  logic             zero_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  ready_o, done_o, s_o, c_o, zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output ready_o, done_o, s_o, c_o, zero_o
  );
endinterface

// File: rtl/e_ppn_add_sub_seq.sv
// Digit-serial add / subtract / reverse-subtract / compare unit with zero flag.
// Operands are latched, then consumed DIGIT bits per cycle, LSB digit first.
module e_ppn_add_sub_seq #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DIGIT = 64
) (
  input logic               clk,
  input logic               reset,
  e_ppn_add_sub_seq_if.slave bus
);

  localparam int unsigned NDIG  = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned XW    = NDIG * DIGIT;
  localparam int unsigned LASTW = WIDTH - (NDIG - 1) * DIGIT;
  localparam int unsigned CW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIGIT-1:0] LAST_MASK = {DIGIT{1'b1}} >> (DIGIT - LASTW);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             nz_q, nz_d;
  logic [1:0]       op_q, op_d;
  logic [XW-1:0]    x_q, x_d;
  logic [XW-1:0]    y_q, y_d;
  logic [XW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] na, nb;
  logic [DIGIT:0]   dsum;
  logic [DIGIT-1:0] dmask;
  logic             last_dig;

  // Next-state, digit datapath and output update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    nz_d     = nz_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    s_d      = s_q;
    c_d      = c_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    na       = ~bus.a_i;
    nb       = ~bus.b_i;
    last_dig = (cnt_q == CW'(NDIG - 1));
    dmask    = last_dig ? LAST_MASK : {DIGIT{1'b1}};
    dsum     = (DIGIT+1)'(x_q[DIGIT-1:0]) + (DIGIT+1)'(y_q[DIGIT-1:0])
             + (DIGIT+1)'(carry_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          nz_d    = 1'b0;
          op_d    = bus.op_i;
          case (bus.op_i)
            2'b00: begin
              x_d = XW'(bus.a_i); y_d = XW'(bus.b_i); carry_d = 1'b0;
            end
            2'b10: begin
              x_d = XW'(bus.b_i); y_d = XW'(na); carry_d = 1'b1;
            end
            default: begin
              x_d = XW'(bus.a_i); y_d = XW'(nb); carry_d = 1'b1;
            end
          endcase
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d     = x_q >> DIGIT;
        y_d     = y_q >> DIGIT;
        acc_d   = XW'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
        carry_d = dsum[DIGIT];
        nz_d    = nz_q | (|(dsum[DIGIT-1:0] & dmask));
        cnt_d   = cnt_q + CW'(1);
        if (last_dig) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          c_d     = dsum[LASTW];
          zero_d  = ~nz_d;
          if (op_q != 2'b11) s_d = acc_d[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      nz_q    <= 1'b0;
      op_q    <= 2'b00;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      nz_q    <= nz_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;
  assign bus.s_o     = s_q;
  assign bus.c_o     = c_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_e_ppn_add_sub_seq.sv
// Directed bench for e_ppn_add_sub_seq: default build plus DIGIT=257/1/100 builds.
module tb_e_ppn_add_sub_seq;
  localparam int unsigned W = 257;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e_ppn_add_sub_seq_if #(.WIDTH(W)) m_if ();
  e_ppn_add_sub_seq_if #(.WIDTH(W)) p0_if ();
  e_ppn_add_sub_seq_if #(.WIDTH(W)) p1_if ();
  e_ppn_add_sub_seq_if #(.WIDTH(W)) p2_if ();

  e_ppn_add_sub_seq #(.WIDTH(W), .DIGIT(64))  u_m  (.clk(clk), .reset(reset), .bus(m_if));
  e_ppn_add_sub_seq #(.WIDTH(W), .DIGIT(257)) u_p0 (.clk(clk), .reset(reset), .bus(p0_if));
  e_ppn_add_sub_seq #(.WIDTH(W), .DIGIT(1))   u_p1 (.clk(clk), .reset(reset), .bus(p1_if));
  e_ppn_add_sub_seq #(.WIDTH(W), .DIGIT(100)) u_p2 (.clk(clk), .reset(reset), .bus(p2_if));

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count edges from the sampling edge until done_o is seen; optionally pulse start mid-run.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        m_if.a_i  = ~m_if.a_i;
        m_if.b_i  = m_if.b_i ^ W'(12345);
        m_if.op_i = ~m_if.op_i;
      end
      m_if.start_i = (lat == pulse_at);
      if (m_if.done_o) break;
    end
  endtask

  task automatic drive_m(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    m_if.op_i = op; m_if.a_i = a; m_if.b_i = b; m_if.start_i = 1'b1;
  endtask

  task automatic run_par(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] es, input logic ec,
                         input logic ez);
    int lat [3];
    logic [W-1:0] ps [3];
    logic pc [3];
    logic pz [3];
    int exp_lat [3];
    exp_lat = '{2, 258, 4};
    lat = '{0, 0, 0};
    @(negedge clk);
    p0_if.op_i = op; p0_if.a_i = a; p0_if.b_i = b; p0_if.start_i = 1'b1;
    p1_if.op_i = op; p1_if.a_i = a; p1_if.b_i = b; p1_if.start_i = 1'b1;
    p2_if.op_i = op; p2_if.a_i = a; p2_if.b_i = b; p2_if.start_i = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      p0_if.start_i = 1'b0; p1_if.start_i = 1'b0; p2_if.start_i = 1'b0;
      if (p0_if.done_o && lat[0] == 0) begin
        lat[0] = n; ps[0] = p0_if.s_o; pc[0] = p0_if.c_o; pz[0] = p0_if.zero_o;
      end
      if (p1_if.done_o && lat[1] == 0) begin
        lat[1] = n; ps[1] = p1_if.s_o; pc[1] = p1_if.c_o; pz[1] = p1_if.zero_o;
      end
      if (p2_if.done_o && lat[2] == 0) begin
        lat[2] = n; ps[2] = p2_if.s_o; pc[2] = p2_if.c_o; pz[2] = p2_if.zero_o;
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lat_%0d", tag, i), (W+1)'(lat[i]), (W+1)'(exp_lat[i]));
      check($sformatf("%s_s_%0d", tag, i), {1'b0, ps[i]}, {1'b0, es});
      check($sformatf("%s_c_%0d", tag, i), (W+1)'(pc[i]), (W+1)'(ec));
      check($sformatf("%s_z_%0d", tag, i), (W+1)'(pz[i]), (W+1)'(ez));
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] big;
    int lat;
    int seen;
    ones = '1;
    big  = W'(65'h1_0000_0000_0000_0001);

    reset = 1'b1;
    m_if.start_i = 1'b0;  m_if.op_i = 2'b00;  m_if.a_i = '0;  m_if.b_i = '0;
    p0_if.start_i = 1'b0; p0_if.op_i = 2'b00; p0_if.a_i = '0; p0_if.b_i = '0;
    p1_if.start_i = 1'b0; p1_if.op_i = 2'b00; p1_if.a_i = '0; p1_if.b_i = '0;
    p2_if.start_i = 1'b0; p2_if.op_i = 2'b00; p2_if.a_i = '0; p2_if.b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", (W+1)'(m_if.ready_o), (W+1)'(1));
    check("rst_done",  (W+1)'(m_if.done_o),  (W+1)'(0));
    check("rst_s",     {1'b0, m_if.s_o},     '0);
    check("rst_c",     (W+1)'(m_if.c_o),     (W+1)'(0));
    check("rst_zero",  (W+1)'(m_if.zero_o),  (W+1)'(0));
    @(negedge clk);
    reset = 1'b0;

    // Add with carry out of the top bit
    @(negedge clk);
    drive_m(2'b00, ones, W'(1));
    wait_done(0, lat);
    check("add_lat",  (W+1)'(lat), (W+1)'(6));
    check("add_s",    {1'b0, m_if.s_o}, '0);
    check("add_c",    (W+1)'(m_if.c_o), (W+1)'(1));
    check("add_zero", (W+1)'(m_if.zero_o), (W+1)'(1));
    @(posedge clk);
    #1;
    check("add_done_pulse", (W+1)'(m_if.done_o), (W+1)'(0));

    // Subtract with borrow
    @(negedge clk);
    drive_m(2'b01, W'(5), W'(7));
    wait_done(0, lat);
    check("sub_s",    {1'b0, m_if.s_o}, {1'b0, ones - W'(1)});
    check("sub_c",    (W+1)'(m_if.c_o), (W+1)'(0));
    check("sub_zero", (W+1)'(m_if.zero_o), (W+1)'(0));

    // Reverse subtract
    @(negedge clk);
    drive_m(2'b10, W'(5), W'(7));
    wait_done(0, lat);
    check("rsub_s", {1'b0, m_if.s_o}, (W+1)'(2));
    check("rsub_c", (W+1)'(m_if.c_o), (W+1)'(1));

    // Add 3+4 with an ignored mid-run start pulse, then back-to-back compares
    @(negedge clk);
    drive_m(2'b00, W'(3), W'(4));
    wait_done(3, lat);
    check("pulse_lat", (W+1)'(lat), (W+1)'(6));
    check("pulse_s",   {1'b0, m_if.s_o}, (W+1)'(7));
    check("done_ready", (W+1)'(m_if.ready_o), (W+1)'(1));
    drive_m(2'b11, big, big);
    wait_done(0, lat);
    check("b2b_gap",   (W+1)'(lat), (W+1)'(6));
    check("cmp_eq_z",  (W+1)'(m_if.zero_o), (W+1)'(1));
    check("cmp_eq_c",  (W+1)'(m_if.c_o), (W+1)'(1));
    check("cmp_eq_s",  {1'b0, m_if.s_o}, (W+1)'(7));
    drive_m(2'b11, W'(3), W'(4));
    wait_done(0, lat);
    check("cmp_lt_z",  (W+1)'(m_if.zero_o), (W+1)'(0));
    check("cmp_lt_c",  (W+1)'(m_if.c_o), (W+1)'(0));
    check("cmp_lt_s",  {1'b0, m_if.s_o}, (W+1)'(7));

    // Compare leaves flags set; then reset lands in the third RUN cycle
    @(posedge clk);
    @(negedge clk);
    drive_m(2'b00, W'(9), W'(9));
    @(posedge clk);
    #1;
    m_if.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("run_ready", (W+1)'(m_if.ready_o), (W+1)'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", (W+1)'(m_if.ready_o), (W+1)'(1));
    check("mid_rst_s",     {1'b0, m_if.s_o}, '0);
    check("mid_rst_c",     (W+1)'(m_if.c_o), (W+1)'(0));
    check("mid_rst_zero",  (W+1)'(m_if.zero_o), (W+1)'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (m_if.done_o) seen++;
    end
    check("mid_rst_no_done", (W+1)'(seen), '0);

    // Other digit widths
    run_par("par_add", 2'b00, ones, W'(1), '0, 1'b1, 1'b1);
    run_par("par_sub", 2'b01, W'(5), W'(7), ones - W'(1), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
